// File: rtl/store_rmw_unit_pkg.sv
// Shared types and helpers for the store read-modify-write unit.
// Optional build macro understood by this slice: STORE_ERR_STATUS_EN.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } store_size_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    ERR   = 3'd4,
    RESP  = 3'd5
  } store_state_t;

  // Low byte-address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input store_size_t size, input logic [1:0] lane);
    case (size)
      SZ_WORD: return (lane & WORD_ALIGN_MASK) != 2'b00;
      SZ_HALF: return lane[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request and memory-port bundle between the datapath, the store unit and data memory.
// Optional build macro understood by this slice: STORE_ERR_STATUS_EN (adds no signals here).
interface store_rmw_unit_if #(
  parameter int ADDR_W = 32
);
  // Request handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_size/req_addr/req_data only matter on that edge, and done (with misaligned on
  // rejection) pulses for exactly one cycle when the accepted request has finished.
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              done;
  logic              misaligned;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_size, req_addr, req_data, mem_rdata,
    output req_ready, done, misaligned, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_size, req_addr, req_data, mem_rdata,
    input  req_ready, done, misaligned, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/store_rmw_unit_lane_merge.sv
// Replaces the addressed byte or half of a memory word with new store data (little-endian).
// Optional build macro understood by this slice: STORE_ERR_STATUS_EN (unused here).
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  store_size_t size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_WORD: merged = new_data;
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
      SZ_BYTE: merged[{lane, 3'b000} +: 8] = new_data[7:0];
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store responder: direct word writes, read-modify-write for sb/sh, rejection of misaligned stores.
// Optional build macro: STORE_ERR_STATUS_EN adds err_addr/err_sticky error status outputs.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  store_rmw_unit_if.slave bus,
  output store_state_t  dbg_state
`ifdef STORE_ERR_STATUS_EN
  ,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_sticky
`endif
);

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  store_state_t      state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  store_size_t       size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              err_flag_q, err_flag_d;
  logic              ready_q, ready_d;
`ifdef STORE_ERR_STATUS_EN
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_sticky_q, err_sticky_d;
`endif

  store_size_t req_size_t;
  logic        req_mis;
  logic [31:0] merged;

  assign req_size_t = store_size_t'(bus.req_size);
  assign req_mis    = is_misaligned(req_size_t, bus.req_addr[1:0]);

  store_lane_merge u_lane_merge (
    .old_word (rdata_q),
    .new_data (data_q),
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .merged   (merged)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    err_flag_d = err_flag_q;
    mem_wr_d   = 1'b0;
    done_d     = 1'b0;
    mis_d      = 1'b0;
`ifdef STORE_ERR_STATUS_EN
    err_addr_d   = err_addr_q;
    err_sticky_d = err_sticky_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d     = req_size_t;
          addr_d     = bus.req_addr;
          data_d     = bus.req_data;
          err_flag_d = req_mis;
          cnt_d      = 2'd0;
`ifdef STORE_ERR_STATUS_EN
          err_addr_d   = req_mis ? bus.req_addr : '0;
          err_sticky_d = req_mis;
`endif
          if (req_mis) begin
            state_d = ERR;
          end else if (req_size_t == SZ_WORD) begin
            // Full words skip the read; the write strobe rises with the WR state.
            wdata_d  = bus.req_data;
            mem_wr_d = 1'b1;
            state_d  = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == LAST_CNT) begin
          rdata_d = bus.mem_rdata;
          state_d = MERGE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      MERGE: begin
        wdata_d  = merged;
        mem_wr_d = 1'b1;
        state_d  = WR;
      end
      WR: begin
        done_d  = 1'b1;
        mis_d   = err_flag_q;
        state_d = RESP;
      end
      ERR: begin
        done_d  = 1'b1;
        mis_d   = err_flag_q;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      size_q     <= SZ_WORD;
      addr_q     <= '0;
      data_q     <= 32'd0;
      rdata_q    <= 32'd0;
      wdata_q    <= 32'd0;
      mem_wr_q   <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      err_flag_q <= 1'b0;
      ready_q    <= 1'b1;
`ifdef STORE_ERR_STATUS_EN
      err_addr_q   <= '0;
      err_sticky_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      mem_wr_q   <= mem_wr_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      err_flag_q <= err_flag_d;
      ready_q    <= ready_d;
`ifdef STORE_ERR_STATUS_EN
      err_addr_q   <= err_addr_d;
      err_sticky_q <= err_sticky_d;
`endif
    end
  end

  // The memory address follows the captured request and therefore holds through IDLE.
  assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.req_ready  = ready_q;
  assign bus.done       = done_q;
  assign bus.misaligned = mis_q;
  assign dbg_state      = state_q;
`ifdef STORE_ERR_STATUS_EN
  assign err_addr   = err_addr_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Memory-write responder for the multicycle core: the store-side counterpart of the load path (memory data register plus load extraction).
- Accepts sw/sh/sb requests from the control unit, using the address from ALUOut and the data from register B.
- Performs a read-modify-write on the word-addressed, synchronous-read data memory for sub-word stores, and a direct write for full words.
- Sits between the datapath and the memory port; it owns mem_addr, mem_wr and mem_wdata while busy.

Parameters:
- RD_LAT, 1, memory read latency in cycles (mem_rdata valid RD_LAT cycles after mem_addr is presented); legal range 1..4.
- ADDR_W, 32, byte-address width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  store request strobe
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at a rising edge
- req_size  in  2  00 word, 01 half, 10 byte, 11 reserved
- req_addr  in  ADDR_W  byte address of the store
- req_data  in  32  store data; the low byte/half is used for sb/sh
- done  out  1  one-cycle pulse when the request completes (success or error)
- misaligned  out  1  one-cycle pulse, coincident with done, when the request was rejected
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wr  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Clock and reset are fixed as above: one clock (clock), with reset asynchronous and active-high.
- Reset values:
  - state=IDLE, req_ready=1, done=0, misaligned=0, mem_wr=0.
  - mem_addr=0, mem_wdata=0, and all captured registers = 0.
  - mem_wr must drop asynchronously with reset.
- On accept:
  - Capture size, addr and data.
  - Classify the request as misaligned if size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
- Lane map (little-endian within a word):
  - Byte k=addr[1:0] occupies bits [8k+7:8k].
  - Half h=addr[1] occupies bits [16h+15:16h].
- States and transitions:
  - IDLE: accept request → ERR if misaligned; WR if word; RD if byte or half.
  - RD: present mem_addr with mem_wr=0; count RD_LAT cycles, then latch mem_rdata → MERGE.
  - MERGE: mem_wdata = latched word with only the target lane replaced by req_data's low byte/half → WR.
  - WR: mem_wr=1 for exactly one cycle with mem_addr held → RESP.
  - ERR: no memory access at all → RESP with the error flag set.
  - RESP: done=1, misaligned=error flag → IDLE.
- Latency (accept edge to done cycle):
  - word: 2 cycles.
  - byte/half: RD_LAT+3 cycles.
  - error: 2 cycles.
- Held inputs:
  - req_valid held high during a busy period is ignored.
  - The next request can be accepted in the cycle after RESP.
  - Inputs other than at accept are don't-care.
- Bus hold:
  - mem_addr holds its value in all non-IDLE states.
  - In IDLE, mem_addr holds the last value; mem_wr is never asserted outside WR.
- Boundary cases:
  - Reset during RD/WR: an aborted write must not occur after reset asserts, and no done is issued.
  - Address 0xFFFFFFFF as a byte store is legal: lane 3 of word 0xFFFFFFFC.
  - Reserved size never touches memory.

Optional Feature:
- Macro: STORE_ERR_STATUS_EN.
- Defined:
  - Adds output err_addr (ADDR_W) and output err_sticky (1).
  - On an ERR request, err_addr ← req_addr and err_sticky ← 1.
  - Both are cleared on the next accepted non-error request and by reset (reset value 0).
- Undefined: these ports and registers do not exist; the error is reported only via the misaligned pulse.

Decomposition:
- Package store_pkg:
  - store_size_t enum (SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10, SZ_RSVD=2'b11).
  - store_state_t enum (IDLE, RD, MERGE, WR, ERR, RESP).
  - Constant WORD_ALIGN_MASK.
- Sub-module store_lane_merge:
  - Combinational.
  - Inputs: old word, new data, size, addr[1:0].
  - Output: merged word.
- The FSM, latency counter and captured registers stay in store_rmw_unit.

Test Plan:
- Word store: req_size=00, addr=0x40, data=0xDEADBEEF → single mem_wr at 0x40 with wdata 0xDEADBEEF; no read cycle; done 2 cycles after accept.
- Byte store: memory[0x40]=0x11223344; sb addr=0x42, data=0x000000AB → read then write 0x11AB3344; done at RD_LAT+3.
- Half store: same word, sh addr=0x42, data=0x0000CAFE → write 0xCAFE3344; sh at addr=0x40 with data 0xBEEF yields 0xCAFEBEEF.
- Misaligned: sh addr=0x41, sw addr=0x46, and size=11 → each gives done+misaligned 2 cycles after accept, mem_wr never asserted; with STORE_ERR_STATUS_EN, err_addr=0x46 after the sw case.
- Reset mid-RMW: sb accepted, reset asserted in RD → mem_wr stays 0, no done, req_ready=1 immediately, memory unchanged.
- Back-to-back: req_valid held high with two queued stores → second accepted only in the cycle after the first done; verify with RD_LAT=1 and RD_LAT=3.
